// File: rtl/linear_layer_seq.sv
// Sequential linear layer: one signed MAC walks an NOUT x NIN weight matrix row-major,
// producing sat((sum_j W[i][j]*x[j]) >>> FRAC) per row behind valid/ready handshakes.
module linear_layer_seq #(
  parameter int WIDTH = 16,
  parameter int NIN   = 4,
  parameter int NOUT  = 3,
  parameter int FRAC  = 8,
  parameter int ACC_W = 2*WIDTH + $clog2(NIN) + 1,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [WIDTH-1:0] in_i [NIN],
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [WIDTH-1:0] out_o [NOUT],
  output logic                    sat_flag_o,
  output logic                    busy_o,
  output logic [1:0]              state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends combinationally on ready, and ready/valid are pure state decodes.

  localparam int ROW_W = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int COL_W = (NIN > 1) ? $clog2(NIN) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   x_q   [NIN];
  logic signed [WIDTH-1:0]   x_d   [NIN];
  logic signed [WIDTH-1:0]   out_q [NOUT];
  logic signed [WIDTH-1:0]   out_d [NOUT];
  logic [ROW_W-1:0]          row_q, row_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      sat_q, sat_d;

  logic signed [WIDTH-1:0]   w_mem [NOUT][NIN];
  logic signed [WIDTH-1:0]   w_sel;
  logic signed [WIDTH-1:0]   x_sel;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   full_sum;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [WIDTH-1:0]   sat_val;
  logic                      clamp;

  // W[0][0] sits in the most significant slice of the flat parameter.
  for (genvar gi = 0; gi < NOUT; gi++) begin : g_row
    for (genvar gj = 0; gj < NIN; gj++) begin : g_col
      assign w_mem[gi][gj] = WEIGHTS_MATRIX_FLAT[(NIN*NOUT-(gi*NIN+gj))*WIDTH-1 -: WIDTH];
    end
  end

  always_comb begin
    w_sel    = w_mem[row_q][col_q];
    x_sel    = x_q[col_q];
    prod     = w_sel * x_sel;
    prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    full_sum = acc_q + prod_ext;
    // Arithmetic shift floors toward -inf; no rounding term is added.
    shifted  = full_sum >>> FRAC;
    clamp    = 1'b0;
    sat_val  = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = OUT_MAX;
      clamp   = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = OUT_MIN;
      clamp   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    out_d   = out_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          x_d     = in_i;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (col_q == COL_W'(NIN-1)) begin
          out_d[row_q] = sat_val;
          sat_d        = sat_q | clamp;
          acc_d        = '0;
          col_d        = '0;
          if (row_q == ROW_W'(NOUT-1)) begin
            row_d   = '0;
            state_d = HOLD;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          acc_d = full_sum;
          col_d = col_q + COL_W'(1);
        end
      end
      HOLD: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      for (int j = 0; j < NIN; j++) x_q[j] <= '0;
      for (int i = 0; i < NOUT; i++) out_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      x_q     <= x_d;
      out_q   <= out_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == HOLD);
  assign out_o       = out_q;
  assign sat_flag_o  = sat_q;
  assign state_o     = state_q;

endmodule
